// File: rtl/player_button_conditioner_pkg.sv
// Shared types for the player button input stage: FSM states, colour codes
// and the one-hot to colour-code helper.
package player_button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_REL
    } btn_state_e;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_e;

    // Bit index of a one-hot button vector; non-one-hot inputs map to RED.
    function automatic color_e onehot_to_color(input logic [3:0] onehot);
        color_e c;
        case (onehot)
            4'b0010: c = GREEN;
            4'b0100: c = BLUE;
            4'b1000: c = YELLOW;
            default: c = RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/player_button_conditioner_sync_2ff.sv
// Parameterised-width two-flop synchroniser with synchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/player_button_conditioner.sv
// Synchronises, debounces and one-hot-validates the four colour buttons and
// emits one press_valid strobe with the colour code per accepted press.
// Optional stuck-button detection is enabled with `define STUCK_DETECT_EN.
module player_button_conditioner
    import player_button_conditioner_pkg::*;
#(
    parameter int COLOR_CODEFY_W  = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STUCK_CYCLES    = 5000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2**COLOR_CODEFY_W-1:0]  raw_buttons,
    input  logic                          accept_en,
    output logic [COLOR_CODEFY_W-1:0]     player_code,
    output logic                          press_valid,
    output logic                          btn_held,
    output logic                          stuck_err
);

    localparam int NUM_BTN = 2**COLOR_CODEFY_W;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s;
    logic [NUM_BTN-1:0] cand;
    logic [CNT_W-1:0]   cnt;
    btn_state_e         state;

    sync_2ff #(
        .WIDTH(NUM_BTN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_buttons),
        .q     (s)
    );

    // Debounce FSM: press must be stable for DEBOUNCE_CYCLES, release likewise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            player_code <= '0;
            press_valid <= 1'b0;
            btn_held    <= 1'b0;
        end else begin
            press_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if ($onehot(s)) begin
                        cand  <= s;
                        cnt   <= '0;
                        state <= DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (s != cand) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state       <= HELD;
                        player_code <= COLOR_CODEFY_W'(onehot_to_color(cand));
                        press_valid <= accept_en;
                        btn_held    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (s == '0) begin
                        cnt   <= '0;
                        state <= DB_REL;
                    end
                end
                DB_REL: begin
                    if (s != '0) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        state    <= IDLE;
                        btn_held <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int HOLD_W = $clog2(STUCK_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Hold timer: cleared on HELD entry, kept across release bounces, flag sticky until IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            stuck_err <= 1'b0;
        end else begin
            case (state)
                DB_PRESS: begin
                    if (s == cand && cnt == CNT_MAX) hold_cnt <= '0;
                end
                HELD: begin
                    if (hold_cnt == HOLD_MAX) stuck_err <= 1'b1;
                    else                      hold_cnt  <= hold_cnt + 1'b1;
                end
                DB_REL: begin
                    if (s == '0 && cnt == CNT_MAX) stuck_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`else
    localparam int unused_stuck_cycles = STUCK_CYCLES;
    assign stuck_err = 1'b0;
`endif

endmodule

// File: tb/tb_player_button_conditioner.sv
// Self-checking bench for player_button_conditioner with DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=10. Build with or without `define STUCK_DETECT_EN.
module tb_player_button_conditioner;

    localparam int DB = 4;
    localparam int ST = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw_buttons = 4'b0;
    logic       accept_en = 1'b1;
    logic [1:0] player_code;
    logic       press_valid;
    logic       btn_held;
    logic       stuck_err;

    int total = 0;
    int bad = 0;

    // Reference model state: pipeline of raw samples plus run-length counters.
    logic [3:0] m_m = '0, m_s = '0, m_cand = '0;
    bit         m_held = 0, m_track = 0;
    int         m_run = 0, m_zero = 0, m_hold = 0;
    logic       exp_pv = 0, exp_stuck = 0;
    logic [1:0] exp_code = '0;

    player_button_conditioner #(
        .COLOR_CODEFY_W (2),
        .DEBOUNCE_CYCLES(DB),
        .STUCK_CYCLES   (ST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_buttons(raw_buttons),
        .accept_en  (accept_en),
        .player_code(player_code),
        .press_valid(press_valid),
        .btn_held   (btn_held),
        .stuck_err  (stuck_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] color_of(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return 2'(k);
        return 2'b00;
    endfunction

    // A press is accepted after DB+1 consecutive identical one-hot samples,
    // a release after DB+1 consecutive all-zero samples; a sample that breaks
    // a press run is discarded. Stuck after ST samples while fully held.
    task automatic model_edge();
        logic [3:0] seen;
        bit held_edge;
        seen = m_s;
        exp_pv = 1'b0;
        if (!rst_n) begin
            m_m = '0; m_s = '0; m_held = 0; m_track = 0;
            m_run = 0; m_zero = 0; m_hold = 0;
            exp_code = '0; exp_stuck = 1'b0;
            return;
        end
        m_s = m_m;
        m_m = raw_buttons;
        held_edge = m_held && (m_zero == 0);
        if (held_edge) begin
            m_hold++;
`ifdef STUCK_DETECT_EN
            if (m_hold >= ST) exp_stuck = 1'b1;
`endif
        end
        if (!m_held) begin
            if (!m_track) begin
                if ($countones(seen) == 1) begin
                    m_track = 1; m_cand = seen; m_run = 1;
                end
            end else if (seen != m_cand) begin
                m_track = 0;
            end else begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_held = 1; m_track = 0; m_zero = 0; m_hold = 0;
                    exp_pv = accept_en;
                    exp_code = color_of(m_cand);
                end
            end
        end else if (seen == '0) begin
            m_zero++;
            if (m_zero == DB + 1) begin
                m_held = 0; m_zero = 0; exp_stuck = 1'b0;
            end
        end else begin
            m_zero = 0;
        end
    endtask

    task automatic tick(input logic [3:0] r);
        raw_buttons = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) tick(4'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick(4'b0);
        total++;
        if ({press_valid, player_code, btn_held, stuck_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", {press_valid, player_code, btn_held, stuck_err}, 5'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int pulses = 0, first = -1;
        for (int i = 0; i < 20; i++) begin
            tick(4'b0100);
            total++;
            if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", i,
                         {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
            end
            if (press_valid) begin pulses++; if (first < 0) first = i; end
        end
        total++;
        if (pulses !== 1 || first !== 6 || player_code !== 2'b10) begin
            bad++;
            $display("FAIL clean_press_timing got pulses=%0d at=%0d code=%b exp pulses=1 at=6 code=10", pulses, first, player_code);
        end
        settle();
    endtask

    task automatic test_bounce();
        int pulses = 0, first = -1;
        for (int i = 0; i < 26; i++) begin
            tick((i < 10 && (i % 2) == 1) ? 4'b0000 : 4'b0001);
            total++;
            if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", i,
                         {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
            end
            if (press_valid) begin pulses++; if (first < 0) first = i; end
        end
        total++;
        if (pulses !== 1 || first !== 16 || player_code !== 2'b00) begin
            bad++;
            $display("FAIL bounce_timing got pulses=%0d at=%0d code=%b exp pulses=1 at=16 code=00", pulses, first, player_code);
        end
    endtask

    task automatic test_release_repress();
        int pulses = 0, first = -1;
        logic [3:0] r;
        for (int i = 0; i < 23; i++) begin
            if (i < 3)       r = (i == 1) ? 4'b0001 : 4'b0000;
            else if (i < 11) r = 4'b0000;
            else             r = 4'b1000;
            tick(r);
            total++;
            if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                bad++;
                $display("FAIL release_repress cyc=%0d got=%b exp=%b", i,
                         {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
            end
            if (press_valid) begin pulses++; if (first < 0) first = i; end
        end
        total++;
        if (pulses !== 1 || first !== 17 || player_code !== 2'b11) begin
            bad++;
            $display("FAIL release_repress_timing got pulses=%0d at=%0d code=%b exp pulses=1 at=17 code=11", pulses, first, player_code);
        end
        settle();
    endtask

    task automatic test_multi_press();
        int pulses = 0, first = -1;
        for (int i = 0; i < 32; i++) begin
            tick(i < 20 ? 4'b0011 : 4'b0010);
            total++;
            if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                bad++;
                $display("FAIL multi_press cyc=%0d got=%b exp=%b", i,
                         {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
            end
            if (i < 20 && btn_held) begin
                bad++;
                $display("FAIL multi_press_held cyc=%0d got=1 exp=0", i);
            end
            if (press_valid) begin pulses++; if (first < 0) first = i; end
        end
        total++;
        if (pulses !== 1 || first !== 26 || player_code !== 2'b01) begin
            bad++;
            $display("FAIL multi_press_timing got pulses=%0d at=%0d code=%b exp pulses=1 at=26 code=01", pulses, first, player_code);
        end
        settle();
    endtask

    task automatic test_accept_en();
        int pulses = 0;
        accept_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(4'b1000);
            total++;
            if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                bad++;
                $display("FAIL accept_en cyc=%0d got=%b exp=%b", i,
                         {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
            end
            if (press_valid) pulses++;
        end
        total++;
        if (pulses !== 0 || player_code !== 2'b11 || btn_held !== 1'b1) begin
            bad++;
            $display("FAIL accept_en_silent got pulses=%0d code=%b held=%b exp pulses=0 code=11 held=1", pulses, player_code, btn_held);
        end
        accept_en = 1'b1;
        settle();
    endtask

    task automatic test_reset_mid_press();
        int pulses = 0;
        for (int i = 0; i < 4; i++) tick(4'b0100);
        rst_n = 1'b0;
        tick(4'b0000);
        total++;
        if ({press_valid, player_code, btn_held, stuck_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_press got=%b exp=%b", {press_valid, player_code, btn_held, stuck_err}, 5'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000);
            if (press_valid) pulses++;
        end
        total++;
        if (pulses !== 0 || btn_held !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_press_after got pulses=%0d held=%b exp pulses=0 held=0", pulses, btn_held);
        end
    endtask

    task automatic test_stuck();
        int first = -1;
        for (int i = 0; i < 40; i++) begin
            tick(i < 30 ? 4'b0001 : 4'b0000);
            total++;
            if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                bad++;
                $display("FAIL stuck cyc=%0d got=%b exp=%b", i,
                         {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
            end
            if (stuck_err && first < 0) first = i;
        end
        total++;
`ifdef STUCK_DETECT_EN
        if (first !== 16 || stuck_err !== 1'b0) begin
            bad++;
            $display("FAIL stuck_timing got first=%0d end=%b exp first=16 end=0", first, stuck_err);
        end
`else
        if (first !== -1) begin
            bad++;
            $display("FAIL stuck_disabled got first=%0d exp never", first);
        end
`endif
    endtask

    task automatic test_random();
        int left = 1500;
        logic [3:0] r;
        int hold;
        while (left > 0) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: r = 4'b0001 << $urandom_range(0, 3);
                5, 6:          r = 4'b0000;
                default:       r = 4'($urandom_range(0, 15));
            endcase
            hold = $urandom_range(1, 12);
            accept_en = ($urandom_range(0, 7) != 0);
            for (int j = 0; j < hold && left > 0; j++) begin
                rst_n = ($urandom_range(0, 199) != 0);
                tick(r);
                left--;
                total++;
                if ({press_valid, player_code, btn_held, stuck_err} !== {exp_pv, exp_code, m_held, exp_stuck}) begin
                    bad++;
                    $display("FAIL random cyc=%0d got=%b exp=%b", 1500 - left,
                             {press_valid, player_code, btn_held, stuck_err}, {exp_pv, exp_code, m_held, exp_stuck});
                end
            end
        end
        rst_n = 1'b1;
        accept_en = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_repress();
        test_multi_press();
        test_accept_en();
        test_reset_mid_press();
        test_stuck();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_button_conditioner.md
Name: player_button_conditioner

Overview:
- Upstream input stage for the Genius game core.
- Takes the four raw, asynchronous, active-high colour push-buttons and synchronises, debounces and one-hot-validates them.
- Encodes each accepted press into the 2-bit colour code the core's player_button input consumes, plus a one-cycle press_valid strobe.
- Guarantees exactly one event per physical press. Releases are debounced before a new press is accepted.

Parameters:
- COLOR_CODEFY_W, 2, width of colour code; button count is 2**COLOR_CODEFY_W = 4.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a press or a release; legal range is 2 or more.
- STUCK_CYCLES, 5000000, held cycles before stuck_err; used only with STUCK_DETECT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- raw_buttons  input  4  asynchronous buttons: [0]=red, [1]=green, [2]=blue, [3]=yellow.
- accept_en  input  1  high lets accepted presses emit press_valid.
- player_code  output  COLOR_CODEFY_W  encoded colour of the last accepted press.
- press_valid  output  1  one-cycle strobe, player_code valid.
- btn_held  output  1  an accepted button is still down (states HELD or DB_REL).
- stuck_err  output  1  button held too long; always 0 without the macro.

Behaviour:
- Reset: all registers are sampled on the clk rising edge while rst_n=0.
  - Reset values: synchroniser 4'b0, state IDLE, cnt 0, cand 0, player_code 0, press_valid 0, btn_held 0, stuck_err 0.
  - A reset mid-press aborts with no strobe. A button still down after reset is treated as a fresh press.
- Synchroniser: two flops per bit; s = second stage. All decisions use s only.
- Encoding: red=00, green=01, blue=10, yellow=11 (bit index of the one-hot vector).
- Counter: cnt width is $clog2(DEBOUNCE_CYCLES). It never wraps; it saturates at DEBOUNCE_CYCLES-1.
- FSM states are IDLE, DB_PRESS, HELD, DB_REL.
- IDLE:
  - s one-hot → cand<=s, cnt<=0, go DB_PRESS.
  - s zero or multi-hot → stay in IDLE; multi-press is silently rejected.
- DB_PRESS:
  - s!=cand → go IDLE, no event.
  - s==cand and cnt<D-1 → cnt++.
  - s==cand and cnt==D-1 → go HELD and register player_code<=enc(cand).
  - press_valid<=accept_en on that edge. With accept_en=0 the press is consumed silently and player_code still updates.
- HELD:
  - s==0 → cnt<=0, go DB_REL.
  - Any other pattern, including extra buttons, is ignored.
- DB_REL:
  - s!=0 → go HELD.
  - s==0 and cnt==D-1 → go IDLE.
  - Otherwise cnt++.
- Latency: a button first sampled at edge e0 and held stable gives press_valid high for exactly the one cycle after edge e0+D+2.
- press_valid is a registered pulse, never longer than one cycle. There is at most one pulse per IDLE→HELD traversal.
- player_code holds its value between presses.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- When defined:
  - A hold counter clears on entry to HELD and increments each cycle in HELD, saturating.
  - When it reaches STUCK_CYCLES-1, stuck_err<=1.
  - stuck_err is sticky until the FSM returns to IDLE or reset. The DB_REL→HELD bounce does not clear the hold counter.
- When undefined: stuck_err is tied to 0 and no hold counter is synthesised.

Decomposition:
- Add to typedefs_pkg:
  - btn_state_e enum: IDLE, DB_PRESS, HELD, DB_REL.
  - color_e enum: RED=0, GREEN=1, BLUE=2, YELLOW=3.
  - A function onehot_to_color.
- Natural sub-module: sync_2ff (parameterised-width two-flop synchroniser), reusable for the start and settings buttons.

Test Plan (all with DEBOUNCE_CYCLES=4, STUCK_CYCLES=10):
- Clean press: raw=4'b0100 from edge 0, held 20 cycles → press_valid pulses once, in the cycle after edge 6; player_code=2'b10; btn_held=1 from that cycle.
- Bounce: raw toggles 0001/0000 every cycle for 10 cycles, then holds 0001 → exactly one pulse, player_code=00, 6 cycles after the stable hold starts; no pulse during bouncing.
- Release bounce and repress: after an accepted press, raw toggles 0/0001 for 3 cycles, then holds 0 for 8 cycles, then presses 1000 → one pulse only for 1000, code=11; no second pulse for 0001.
- Multi-press: raw=4'b0011 held 20 cycles → no pulse, state stays IDLE. Then raw=0010 → pulse, code=01.
- accept_en=0 during a press of 1000 → no pulse, player_code=11, btn_held=1. Reset mid-DB_PRESS (rst_n low 1 cycle) → no pulse and all outputs 0.
- STUCK_DETECT_EN: hold 0001 for 30 cycles → stuck_err=1 from 10 cycles after HELD entry. It clears when the FSM returns to IDLE after release. Without the macro, stuck_err=0 throughout.
